fft_sample_loader: RTL and testbench

- Upstream feeder for the FFT core. Accepts a valid/ready stream of complex samples.
- Writes each sample into the real and imag dual-port SRAMs through port 0, at the bit-reversed address the in-place FFT expects.
- After N samples it raises compute_start and holds it until compute_finish rises, then signals frame completion.
- Sits between the sample source and the SRAM/FFT pair. It owns SRAM port 0 only while loading.

---
 rtl/fft_pkg.sv | 32 +++
 rtl/fft_bitrev.sv | 21 ++
 rtl/fft_sample_loader.sv | 156 +++++++++++++++
 tb/tb_fft_sample_loader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
//   Shared definitions for the FFT sample loader and its sibling blocks.
//   The state encoding is fixed so that other blocks can decode a state
//   value they receive, and the write-enable constants match the byte
//   enables of the 32-bit SRAM macros.
// ---------------------------------------------------------------------------
package fft_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  typedef logic [2:0] state_t;

  localparam state_t IDLE  = 3'd0;
  localparam state_t LOAD  = 3'd1;
  localparam state_t START = 3'd2;
  localparam state_t WAIT  = 3'd3;
  localparam state_t DONE  = 3'd4;

  localparam logic [3:0] WEA_ALL  = 4'hF;
  localparam logic [3:0] WEA_NONE = 4'h0;

  // A single write to both SRAMs. The real and imag halves always share
  // one address because the two SRAMs are written in lockstep.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
  } wr_req_t;

endpackage

// File: rtl/fft_bitrev.sv
// ---------------------------------------------------------------------------
// fft_bitrev
//   Purely combinational W-bit bit reverser: out_o[i] = in_i[W-1-i].
//   It is shared by the sample loader and the result unloader.
//
// Ports
//   in_i   [W-1:0]  index in natural order
//   out_o  [W-1:0]  the same index with its bit order reversed
// ---------------------------------------------------------------------------
module fft_bitrev #(
  parameter int W = 8
) (
  input  logic [W-1:0] in_i,
  output logic [W-1:0] out_o
);

  for (genvar i = 0; i < W; i++) begin : g_rev
    assign out_o[i] = in_i[W-1-i];
  end

endmodule

// File: rtl/fft_sample_loader.sv
// ---------------------------------------------------------------------------
// fft_sample_loader
//   Upstream feeder for the in-place FFT core. It takes one frame of N =
//   2**LOG2_N complex samples from a valid/ready stream and writes each one
//   into the real and imag SRAMs through port 0. It then requests a compute
//   and waits for the core to finish.
//
//   Build option
//     FFT_LOADER_BITREV_EN  defined   : addr = BASE_ADDR + bitrev(cnt)
//                           undefined : addr = BASE_ADDR + cnt (natural)
//   All timing is the same in both builds.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   load_en               arms one frame; only looked at in IDLE
//   s_valid/s_ready       sample handshake; s_ready is high only in LOAD
//   s_real, s_imag        32-bit two's-complement sample halves
//   sram_{real,imag}_*0   port-0 write interface (wea / addr / wdata)
//   compute_start         level request to the FFT core
//   compute_finish        sticky done flag from the FFT core
//   busy                  high whenever the loader is not in IDLE
//   frame_done            one-cycle pulse once the FFT result is ready
// ---------------------------------------------------------------------------
module fft_sample_loader
  import fft_pkg::*;
#(
  parameter int          LOG2_N    = 8,
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_real,
  input  logic [DATA_W-1:0] s_imag,
  output logic [3:0]        sram_real_wea0,
  output logic [ADDR_W-1:0] sram_real_addr0,
  output logic [DATA_W-1:0] sram_real_wdata0,
  output logic [3:0]        sram_imag_wea0,
  output logic [ADDR_W-1:0] sram_imag_addr0,
  output logic [DATA_W-1:0] sram_imag_wdata0,
  output logic              compute_start,
  input  logic              compute_finish,
  output logic              busy,
  output logic              frame_done
);

`ifdef FFT_LOADER_BITREV_EN
  localparam bit BITREV = 1'b1;
`else
  localparam bit BITREV = 1'b0;
`endif

  state_t              state_q, state_d;
  logic [LOG2_N-1:0]   cnt_q, cnt_d;
  logic [LOG2_N-1:0]   idx_rev, idx;
  logic                fin_dly_q;
  logic                cs_q, cs_d;
  logic                wr_vld_q;
  wr_req_t             wr_q, wr_d;
  logic                accept, last, fin_rise;

  // The reverser is always instantiated. The build option only selects
  // which index reaches the address adder, and the unused path is removed
  // as constant logic.
  fft_bitrev #(.W(LOG2_N)) u_bitrev (
    .in_i  (cnt_q),
    .out_o (idx_rev)
  );

  assign idx = BITREV ? idx_rev : cnt_q;

  // s_ready is a pure function of the state, so an acceptance can only
  // happen in LOAD. This is why s_valid in any other state has no effect.
  assign accept   = s_valid && (state_q == LOAD);
  assign last     = &cnt_q;
  assign fin_rise = compute_finish && !fin_dly_q;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      fin_dly_q <= 1'b0;
      cs_q      <= 1'b0;
      wr_vld_q  <= 1'b0;
      wr_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fin_dly_q <= compute_finish;
      cs_q      <= cs_d;
      wr_vld_q  <= accept;
      if (accept) wr_q <= wr_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (load_en) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          // The counter wraps to 0 after the last sample of the frame.
          cnt_d = cnt_q + LOG2_N'(1);
          if (last) state_d = START;
        end
      end
      // A compute_finish left high by the previous frame must go low first.
      // Otherwise its stale level would look like completion of this frame.
      START:   if (!compute_finish) state_d = WAIT;
      WAIT:    if (fin_rise)        state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic
  // -------------------------------------------------------------------------
  always_comb begin
    s_ready    = (state_q == LOAD);
    busy       = (state_q != IDLE);
    frame_done = (state_q == DONE);
    // compute_start is registered. It therefore rises one cycle after the
    // final SRAM write, which lands in the first START cycle. It falls in
    // the same cycle that DONE is entered.
    cs_d       = ((state_q == START) || (state_q == WAIT)) && (state_d != DONE);
    // Zero-extend the index to the address width. The 16-bit add wraps.
    wr_d.addr  = BASE_ADDR + {{(ADDR_W-LOG2_N){1'b0}}, idx};
    wr_d.re    = s_real;
    wr_d.im    = s_imag;
  end

  assign compute_start    = cs_q;

  assign sram_real_wea0   = wr_vld_q ? WEA_ALL : WEA_NONE;
  assign sram_real_addr0  = wr_q.addr;
  assign sram_real_wdata0 = wr_q.re;
  assign sram_imag_wea0   = wr_vld_q ? WEA_ALL : WEA_NONE;
  assign sram_imag_addr0  = wr_q.addr;
  assign sram_imag_wdata0 = wr_q.im;

endmodule

// File: tb/tb_fft_sample_loader.sv
// ---------------------------------------------------------------------------
// tb_fft_sample_loader
//   Directed and randomized bench for fft_sample_loader with LOG2_N=3 and
//   BASE_ADDR=16'h0010. Expected write addresses follow the same build
//   option as the DUT (FFT_LOADER_BITREV_EN).
// ---------------------------------------------------------------------------
module tb_fft_sample_loader;

  localparam int          L    = 3;
  localparam int          N    = 1 << L;
  localparam logic [15:0] BASE = 16'h0010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_en = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_real = '0;
  logic [31:0] s_imag = '0;
  logic [3:0]  r_wea, i_wea;
  logic [15:0] r_addr, i_addr;
  logic [31:0] r_wdata, i_wdata;
  logic        compute_start;
  logic        compute_finish = 1'b0;
  logic        busy;
  logic        frame_done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fft_sample_loader #(.LOG2_N(L), .BASE_ADDR(BASE)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .load_en          (load_en),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .s_real           (s_real),
    .s_imag           (s_imag),
    .sram_real_wea0   (r_wea),
    .sram_real_addr0  (r_addr),
    .sram_real_wdata0 (r_wdata),
    .sram_imag_wea0   (i_wea),
    .sram_imag_addr0  (i_addr),
    .sram_imag_wdata0 (i_wdata),
    .compute_start    (compute_start),
    .compute_finish   (compute_finish),
    .busy             (busy),
    .frame_done       (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected address of the k-th sample in a frame.
  function automatic logic [15:0] exp_addr(input int k);
    int r;
    r = 0;
`ifdef FFT_LOADER_BITREV_EN
    for (int b = 0; b < L; b++)
      if (((k >> b) & 1) != 0) r = r | (1 << (L - 1 - b));
`else
    r = k;
`endif
    return 16'(int'(BASE) + r);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rwea"},  32'(r_wea),   32'h0);
    chk({tag, "_iwea"},  32'(i_wea),   32'h0);
    chk({tag, "_raddr"}, 32'(r_addr),  32'h0);
    chk({tag, "_iaddr"}, 32'(i_addr),  32'h0);
    chk({tag, "_rdata"}, r_wdata,      32'h0);
    chk({tag, "_idata"}, i_wdata,      32'h0);
    chk({tag, "_ready"}, 32'(s_ready), 32'h0);
    chk({tag, "_cs"},    32'(compute_start), 32'h0);
    chk({tag, "_busy"},  32'(busy),    32'h0);
    chk({tag, "_done"},  32'(frame_done), 32'h0);
  endtask

  // Stream samples until stop_at have been accepted, checking every cycle.
  // Each cycle has either the one-cycle-late write of the previous
  // acceptance or no write at all.
  // mode 0: always valid, data real=k imag=-k
  // mode 1: valid pattern 1,0,0 repeating, random data
  // mode 2: random valid, random data
  task automatic run_load(input bit arm, input int mode, input int stop_at);
    int k, cyc, pk;
    bit pend, v;
    logic [31:0] pre, pim;
    k = 0; cyc = 0; pend = 0; pk = 0; pre = '0; pim = '0;
    if (arm) begin
      chk("idle_ready", 32'(s_ready), 32'h0);
      load_en = 1'b1;
      step();
      load_en = 1'b0;
    end
    forever begin
      if (pend) begin
        chk("wr_rwea",  32'(r_wea),  32'hF);
        chk("wr_iwea",  32'(i_wea),  32'hF);
        chk("wr_raddr", 32'(r_addr), 32'(exp_addr(pk)));
        chk("wr_iaddr", 32'(i_addr), 32'(exp_addr(pk)));
        chk("wr_rdata", r_wdata, pre);
        chk("wr_idata", i_wdata, pim);
      end else begin
        chk("gap_rwea", 32'(r_wea), 32'h0);
        chk("gap_iwea", 32'(i_wea), 32'h0);
      end
      chk("load_ready", 32'(s_ready), 32'(k < N));
      if (k == stop_at) begin
        if (k == N) begin
          chk("last_wr_cs",   32'(compute_start), 32'h0);
          chk("last_wr_busy", 32'(busy), 32'h1);
        end
        break;
      end
      if (cyc == 200) begin
        chk("load_timeout", 32'(k), 32'(stop_at));
        break;
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 3) == 0;
        default: v = 1'($urandom_range(0, 1));
      endcase
      s_valid = v;
      s_real  = (mode == 0) ? 32'(k)  : $urandom;
      s_imag  = (mode == 0) ? 32'(-k) : $urandom;
      step();
      cyc++;
      pend = v;
      if (v) begin
        pk = k; pre = s_real; pim = s_imag;
        k++;
      end
    end
    s_valid = 1'b0;
  endtask

  initial begin
    // Reset state.
    #3;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Samples offered while idle must be ignored.
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_real = $urandom; s_imag = $urandom;
      step();
      chk("idle_wea",  32'(r_wea), 32'h0);
      chk("idle_busy", 32'(busy),  32'h0);
    end
    s_valid = 1'b0;

    // Frame 1: unbroken stream, then the completion handshake.
    run_load(1'b1, 0, N);
    step();
    chk("f1_cs_rise", 32'(compute_start), 32'h1);
    chk("f1_post_wea", 32'(r_wea), 32'h0);
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'($urandom_range(0, 1));
      chk("f1_wait_cs",   32'(compute_start), 32'h1);
      chk("f1_wait_done", 32'(frame_done), 32'h0);
      chk("f1_wait_busy", 32'(busy), 32'h1);
      chk("f1_wait_wea",  32'(r_wea), 32'h0);
      step();
    end
    s_valid = 1'b0;
    compute_finish = 1'b1;
    step();
    chk("f1_cs_fall", 32'(compute_start), 32'h0);
    chk("f1_done",    32'(frame_done), 32'h1);
    step();
    chk("f1_done_pulse", 32'(frame_done), 32'h0);
    chk("f1_busy_fall",  32'(busy), 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("f1_no_2nd_done", 32'(frame_done), 32'h0);
    end

    // Frame 2: gappy stream while compute_finish is still sticky high.
    run_load(1'b1, 1, N);
    step();
    chk("f2_cs_rise", 32'(compute_start), 32'h1);
    for (int i = 0; i < 10; i++) begin
      chk("f2_sticky_cs",   32'(compute_start), 32'h1);
      chk("f2_sticky_done", 32'(frame_done), 32'h0);
      step();
    end
    compute_finish = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("f2_low_cs",   32'(compute_start), 32'h1);
      chk("f2_low_done", 32'(frame_done), 32'h0);
    end
    compute_finish = 1'b1;
    load_en = 1'b1;        // held high: should re-arm after one idle cycle
    step();
    chk("f2_done", 32'(frame_done), 32'h1);
    chk("f2_cs_fall", 32'(compute_start), 32'h0);
    step();
    chk("rearm_idle_busy",  32'(busy), 32'h0);
    chk("rearm_idle_ready", 32'(s_ready), 32'h0);
    step();
    load_en = 1'b0;
    chk("rearm_load_busy", 32'(busy), 32'h1);

    // Frame 3: reset hits after 5 samples.
    compute_finish = 1'b0;
    run_load(1'b0, 2, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_reset_busy", 32'(busy), 32'h0);

    // Frame 4: restarts from sample 0 at the base address.
    run_load(1'b1, 2, N);
    step();
    chk("f4_cs_rise", 32'(compute_start), 32'h1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("f4_wait_done", 32'(frame_done), 32'h0);
    end
    compute_finish = 1'b1;
    step();
    chk("f4_done", 32'(frame_done), 32'h1);
    step();
    chk("f4_busy_fall", 32'(busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
